gactx_seq_unpacker: RTL
=======================

GACTX_SEQ_UNPACKER -- requirements
Module: gactx_seq_unpacker

Interface
REQ-001 Parameter IN_W, default 1024, SHALL set the input word width: IN_W/8 ASCII bases per word, byte 0 in bits [7:0] is the first base.
REQ-002 Parameter OUT_BASES, default 32, SHALL set the number of encoded bases per output beat.
REQ-003 Parameter BASE_W, default 3, SHALL set the encoded base width.
REQ-004 ap_clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 areset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  in  1  SHALL be a one-cycle pulse that begins a sequence.
REQ-007 seq_len  in  32  SHALL give the base count, sampled on the start cycle.
REQ-008 done  out  1  SHALL be a one-cycle completion pulse.
REQ-009 error  out  1  SHALL be a sticky short-input flag.
REQ-010 s_valid/s_ready/s_data[IN_W-1:0]/s_last SHALL form the input word stream from the AXI read path.
REQ-011 m_valid/m_ready/m_data[OUT_BASES*BASE_W-1:0]/m_last/m_count[$clog2(OUT_BASES+1)-1:0] SHALL form the encoded output stream to the GACT-X array.

Function
REQ-012 Encoding SHALL be: A/a=0, C/c=1, G/g=2, T/t=3, any other byte=4 (N).
REQ-013 Base k of a beat SHALL occupy m_data[k*BASE_W +: BASE_W].
REQ-014 Positions at or beyond the sequence end SHALL be padded with code 4.
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD, EMIT.
REQ-016 In IDLE, start with seq_len>0 SHALL capture seq_len into a remaining-count register and enter LOAD.
REQ-017 In IDLE, start with seq_len=0 SHALL pulse done on the next cycle, stay in IDLE, and consume no input.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 s_ready SHALL be high in LOAD.
REQ-020 s_ready SHALL also be high in EMIT when the current beat is the word's last chunk, m_ready=1, and the remaining count after this beat is >0; in that case the next word is accepted that cycle (zero-bubble throughput).
REQ-021 An accepted word SHALL be registered, and m_valid SHALL rise on the following cycle (one-cycle latency).
REQ-022 Each word SHALL yield IN_W/(8*OUT_BASES) chunks (4 by default), emitted in byte order.
REQ-023 m_data, m_last and m_count SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 m_count SHALL equal min(OUT_BASES, remaining).
REQ-025 On each accepted beat, remaining SHALL decrement by m_count.
REQ-026 m_last SHALL be high on the beat where remaining reaches 0.
REQ-027 After the m_last beat is accepted, done SHALL pulse the next cycle and the FSM SHALL return to IDLE; unused chunks of the final word are discarded.
REQ-028 If s_last is accepted and that word cannot supply all remaining bases, the final available chunk SHALL carry m_last=1, error SHALL set, and done SHALL pulse after that beat is accepted.
REQ-029 error SHALL clear on the next accepted start.
REQ-030 s_last on a word that covers the remaining bases exactly SHALL be normal completion, with no error.
REQ-031 The remaining count SHALL be 32-bit unsigned, and its decrement SHALL never underflow.

Reset
REQ-032 areset SHALL force state=IDLE, m_valid=0, s_ready=0, done=0, error=0, m_last=0, m_count=0, m_data=0, remaining=0.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence without a done pulse.
REQ-034 After reset, the first start SHALL behave as after power-up.

Structure
REQ-035 Package gactx_pkg SHALL hold the base-code constants (A,C,G,T,N), BASE_W, and the FSM state enum type.
REQ-036 Byte-to-code conversion SHALL be a combinational sub-module gactx_base_encoder, instantiated OUT_BASES times on the selected chunk.

Verification
REQ-037 Exact sequence: seq_len=256, two words of "ACGT" repeated, m_ready=1 -> 8 beats, codes 0,1,2,3 repeating, m_count=32 each, m_last on beat 8, done one cycle later, no idle cycle between words.
REQ-038 Partial beat: seq_len=40, one word -> beat 1 m_count=32; beat 2 m_count=8, positions 8..31 code 4, m_last=1; remaining chunks discarded; done.
REQ-039 Zero length: start with seq_len=0 -> done the next cycle, s_ready never high, m_valid never high.
REQ-040 Short input: seq_len=300, s_last on word 2 -> m_last on beat 8, error=1, done pulses; the next start clears error.
REQ-041 Backpressure: random m_ready at 30% duty with seq_len=200 and lowercase/"N"/"X" bytes -> output stable while stalled, 'x' encoded as 4, 7 beats total.
REQ-042 Reset mid-EMIT: assert areset during beat 3 -> all outputs reach reset values asynchronously, no done; a subsequent seq_len=32 run completes normally.

Source files
------------

// File: rtl/gactx_pkg.sv
// Shared base codes, code width and FSM state type for the GACT-X sequence unpacker.
package gactx_pkg;

  localparam int unsigned BASE_W = 3;

  localparam logic [BASE_W-1:0] CODE_A = 3'd0;
  localparam logic [BASE_W-1:0] CODE_C = 3'd1;
  localparam logic [BASE_W-1:0] CODE_G = 3'd2;
  localparam logic [BASE_W-1:0] CODE_T = 3'd3;
  localparam logic [BASE_W-1:0] CODE_N = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/gactx_base_encoder.sv
// Maps one ASCII nucleotide byte to its base code; anything unrecognised becomes N.
module gactx_base_encoder
  import gactx_pkg::*;
(
  input  logic [7:0]        byte_i,
  output logic [BASE_W-1:0] code_o
);

  // Case-insensitive ACGT lookup, everything else is N
  always_comb begin
    code_o = CODE_N;
    case (byte_i)
      8'h41, 8'h61: code_o = CODE_A;
      8'h43, 8'h63: code_o = CODE_C;
      8'h47, 8'h67: code_o = CODE_G;
      8'h54, 8'h74: code_o = CODE_T;
      default:      code_o = CODE_N;
    endcase
  end

endmodule

// File: rtl/gactx_seq_unpacker.sv
// Unpacks wide ASCII read-path words into fixed-size beats of encoded bases.
module gactx_seq_unpacker #(
  parameter int unsigned IN_W      = 1024,
  parameter int unsigned OUT_BASES = 32,
  parameter int unsigned BASE_W    = 3
) (
  input  logic                                 ap_clk,
  input  logic                                 areset,
  input  logic                                 start,
  input  logic [31:0]                          seq_len,
  output logic                                 done,
  output logic                                 error,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [IN_W-1:0]                      s_data,
  input  logic                                 s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [OUT_BASES*BASE_W-1:0]          m_data,
  output logic                                 m_last,
  output logic [$clog2(OUT_BASES+1)-1:0]       m_count
);

  import gactx_pkg::*;

  localparam int unsigned CHUNK_BITS = 8 * OUT_BASES;
  localparam int unsigned CHUNKS     = IN_W / CHUNK_BITS;
  localparam int unsigned CIDX_W     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned CNT_W      = $clog2(OUT_BASES + 1);
  localparam int unsigned DATA_W     = OUT_BASES * BASE_W;
  localparam int unsigned ENC_W      = gactx_pkg::BASE_W;

  state_e              state_q, state_d;
  logic [31:0]         rem_q, rem_d;
  logic [IN_W-1:0]     word_q, word_d;
  logic                word_last_q, word_last_d;
  logic [CIDX_W-1:0]   chunk_q, chunk_d;
  logic                short_q, short_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic [CNT_W-1:0]    m_count_q, m_count_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                beat_acc, word_acc, last_chunk, s_ready_c;
  logic [31:0]         rem_after, rem_nb;
  logic [CIDX_W-1:0]   chunk_nxt;
  logic [CHUNK_BITS-1:0] chunk_sel;
  logic [OUT_BASES*ENC_W-1:0] enc_flat;
  logic                nb_idx_last, nb_word_last, nb_end, nb_short;
  logic [CNT_W-1:0]    nb_cnt;
  logic [DATA_W-1:0]   nb_data;

  // Handshake qualifiers and the zero-bubble input-ready rule
  always_comb begin
    beat_acc   = m_valid_q & m_ready;
    rem_after  = rem_q - 32'(m_count_q);
    last_chunk = (chunk_q == CIDX_W'(CHUNKS - 1));
    chunk_nxt  = chunk_q + CIDX_W'(1);
    s_ready_c  = 1'b0;
    if (state_q == ST_LOAD) begin
      s_ready_c = 1'b1;
    end else if (state_q == ST_EMIT) begin
      s_ready_c = last_chunk & beat_acc & ~m_last_q & (rem_after != 32'd0);
    end
    word_acc = s_valid & s_ready_c;
  end

  // Select the chunk that forms the next beat: chunk 0 of a fresh word, else the next stored chunk
  always_comb begin
    chunk_sel    = word_acc ? s_data[CHUNK_BITS-1:0]
                            : CHUNK_BITS'(word_q >> (32'(chunk_nxt) * CHUNK_BITS));
    nb_idx_last  = word_acc ? (CHUNKS == 1) : (chunk_nxt == CIDX_W'(CHUNKS - 1));
    nb_word_last = word_acc ? s_last : word_last_q;
    rem_nb       = (state_q == ST_EMIT) ? rem_after : rem_q;
    nb_end       = (rem_nb <= OUT_BASES);
    nb_short     = nb_word_last & nb_idx_last & ~nb_end;
    nb_cnt       = nb_end ? CNT_W'(rem_nb) : CNT_W'(OUT_BASES);
  end

  for (genvar k = 0; k < OUT_BASES; k++) begin : g_enc
    gactx_base_encoder u_enc (
      .byte_i (chunk_sel[8*k +: 8]),
      .code_o (enc_flat[ENC_W*k +: ENC_W])
    );
  end

  // Pad positions past the sequence end with N
  always_comb begin
    nb_data = '0;
    for (int unsigned k = 0; k < OUT_BASES; k++) begin
      nb_data[k*BASE_W +: BASE_W] = (k < 32'(nb_cnt)) ? BASE_W'(enc_flat[k*ENC_W +: ENC_W])
                                                      : BASE_W'(CODE_N);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    word_d      = word_q;
    word_last_d = word_last_q;
    chunk_d     = chunk_q;
    short_d     = short_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_count_d   = m_count_q;
    done_d      = 1'b0;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (seq_len != 32'd0) begin
            rem_d   = seq_len;
            state_d = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (word_acc) begin
          word_d      = s_data;
          word_last_d = s_last;
          chunk_d     = '0;
          m_valid_d   = 1'b1;
          m_data_d    = nb_data;
          m_count_d   = nb_cnt;
          m_last_d    = nb_end | nb_short;
          short_d     = nb_short;
          state_d     = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (beat_acc) begin
          rem_d = rem_after;
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_count_d = '0;
            done_d    = 1'b1;
            error_d   = error_q | short_q;
            state_d   = ST_IDLE;
          end else if (!last_chunk || word_acc) begin
            if (word_acc) begin
              word_d      = s_data;
              word_last_d = s_last;
              chunk_d     = '0;
            end else begin
              chunk_d = chunk_nxt;
            end
            m_data_d  = nb_data;
            m_count_d = nb_cnt;
            m_last_d  = nb_end | nb_short;
            short_d   = nb_short;
          end else begin
            m_valid_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      word_q      <= '0;
      word_last_q <= 1'b0;
      chunk_q     <= '0;
      short_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_count_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      word_q      <= word_d;
      word_last_q <= word_last_d;
      chunk_q     <= chunk_d;
      short_q     <= short_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_count_q   <= m_count_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign s_ready = s_ready_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_count = m_count_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule
